// File: rtl/bm_lut_arbiter_pkg.sv
// Shared definitions for the round-robin lookup arbiter.
// Contents: FSM state encodings, default sizes and the width of the grant
// statistics counters.
package bm_lut_arbiter_pkg;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 4;
  localparam int STAT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
endpackage

// File: rtl/bm_lut_stage.sv
// Registered WIDTH-bit complement lookup: out = (2^WIDTH-1) - in.
// Ports:
//   clock : rising-edge clock
//   in    : operand
//   out   : registered complement of the operand
// This stage has no reset. The arbiter qualifies the output with its own
// response state, so the register's contents do not matter until a result
// has been computed.
module bm_lut_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  // A bitwise inverse equals the all-ones value minus the operand. The
  // result is exactly WIDTH bits wide and has no carry.
  always_ff @(posedge clock) out <= ~in;
endmodule

// File: rtl/bm_lut_arbiter.sv
// Round-robin arbiter and sequencer in front of one shared registered lookup
// stage. The block accepts one request at a time. It returns the result
// tagged with the index of the requester and holds the result until the
// consumer takes it.
// Ports:
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   req_valid/ready   : per-requester handshake; req_ready is a one-hot grant
//   req_data          : operands; requester i is at [i*WIDTH +: WIDTH]
//   rsp_valid/ready   : result handshake
//   rsp_id, rsp_data  : index of the result owner, and the result
//   busy              : high while a lookup or a response is in flight
//   stat_grants       : per-requester 8-bit saturating grant counters
//                       (only present when LUT_ARB_STATS_EN is defined)
// Optional feature macro: LUT_ARB_STATS_EN
module bm_lut_arbiter
  import bm_lut_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [ID_W-1:0]           rsp_id,
  output logic [WIDTH-1:0]          rsp_data,
  input  logic                      rsp_ready,
  output logic                      busy
`ifdef LUT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0] stat_grants
`endif
);
  state_t             state, state_n;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  int                 idx;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH-1:0]   stage_out;
  logic               accept;

  // Scan starts at rr_ptr and wraps. The first valid requester wins.
  always_comb begin
    grant = '0;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        win        = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

  assign req_ready = (state == ST_IDLE && !reset) ? grant : '0;
  assign accept    = |req_ready;

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:   if (accept) state_n = ST_LOOKUP;
      ST_LOOKUP: state_n = ST_RESP;
      ST_RESP:   if (rsp_ready) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      rsp_id  <= '0;
      operand <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        operand <= req_data[int'(win)*WIDTH +: WIDTH];
        rsp_id  <= win;
        rr_ptr  <= (int'(win) == NUM_REQ-1) ? '0 : win + 1'b1;
      end
    end
  end

  // The operand stays latched through LOOKUP and RESP, so the stage output
  // is stable for as long as the response is held.
  bm_lut_stage #(.WIDTH(WIDTH)) u_stage (
    .clock (clock),
    .in    (operand),
    .out   (stage_out)
  );

  assign rsp_valid = (state == ST_RESP);
  assign rsp_data  = rsp_valid ? stage_out : '0;
  assign busy      = (state != ST_IDLE);

`ifdef LUT_ARB_STATS_EN
  logic [NUM_REQ-1:0][STAT_W-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) cnt <= '0;
    else if (accept && cnt[win] != '1) cnt[win] <= cnt[win] + 1'b1;
  end

  assign stat_grants = cnt;
`endif
endmodule
